// File: rtl/cube_scan_sequencer.sv
// cube_scan_sequencer
// Drives the motor controller through SETUP / U x BATCH / UNDO moves for each batch
// of stickers. After each settled move it samples the corner or edge colour sensor
// and assembles the packed cube state for the solver.
//
// Ports
//   i_clock         system clock, all logic on posedge
//   i_reset         asynchronous active-high reset
//   i_start         begin a scan (accepted only when idle or done)
//   i_corner_color  corner sensor reading (used for sticker indices < N_CORNER)
//   i_edge_color    edge sensor reading (used for the remaining indices)
//   i_done_turning  1-cycle pulse: the requested move has finished
//   o_move_req      1-cycle pulse: execute o_move_code
//   o_move_code     {kind[1:0], batch[3:0]}, kind 0=SETUP 1=U 2=UNDO
//   o_cubestate     sticker i at [i*COLOR_W +: COLOR_W]
//   o_busy          scan in progress
//   o_state_valid   o_cubestate holds a complete scan
//   o_err_color     sticky: an illegal colour (>5) was sampled this scan
//   o_err_timeout   sticky: done_turning did not arrive within TIMEOUT_CYCLES
module cube_scan_sequencer #(
  parameter int COLOR_W        = 3,
  parameter int N_STICKERS     = 48,
  parameter int N_CORNER       = 24,
  parameter int BATCH          = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [COLOR_W-1:0]            i_corner_color,
  input  logic [COLOR_W-1:0]            i_edge_color,
  input  logic                          i_done_turning,
  output logic                          o_move_req,
  output logic [5:0]                    o_move_code,
  output logic [N_STICKERS*COLOR_W-1:0] o_cubestate,
  output logic                          o_busy,
  output logic                          o_state_valid,
  output logic                          o_err_color,
  output logic                          o_err_timeout
);

  localparam int NB     = N_STICKERS / BATCH;
  localparam int IDX_W  = $clog2(N_STICKERS);
  localparam int STEP_W = $clog2(BATCH + 2);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] KIND_SETUP = 2'd0;
  localparam logic [1:0] KIND_U     = 2'd1;
  localparam logic [1:0] KIND_UNDO  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                        r_state;
  logic [3:0]                    r_batch;
  logic [STEP_W-1:0]             r_step;
  logic [IDX_W-1:0]              r_index;
  logic [SET_W-1:0]              r_settle;
  logic [TMO_W-1:0]              r_tmo;
  logic                          r_move_req;
  logic [5:0]                    r_move_code;
  logic [N_STICKERS*COLOR_W-1:0] r_cubestate;
  logic                          r_busy;
  logic                          r_state_valid;
  logic                          r_err_color;
  logic                          r_err_timeout;

  state_t                        w_dec_state;
  logic [3:0]                    w_dec_batch;
  logic [STEP_W-1:0]             w_dec_step;
  logic                          w_decide;
  logic [COLOR_W-1:0]            w_sample;

  // Step 0 positions the batch, the middle steps are U turns, the last step undoes the setup.
  function automatic logic [5:0] f_move_code(input logic [STEP_W-1:0] step,
                                             input logic [3:0]        batch);
    if (step == '0) begin
      return {KIND_SETUP, batch};
    end else if (step == STEP_W'(BATCH + 1)) begin
      return {KIND_UNDO, batch};
    end else begin
      return {KIND_U, batch};
    end
  endfunction

  // Post-move decision: where the sequence goes once a move has settled.
  always_comb begin
    w_dec_state = S_ISSUE;
    w_dec_step  = r_step;
    w_dec_batch = r_batch;
    if (r_step < STEP_W'(BATCH)) begin
      w_dec_state = S_SAMPLE;
    end else if (r_step == STEP_W'(BATCH)) begin
      w_dec_step = STEP_W'(BATCH + 1);
    end else if (r_batch == 4'(NB - 1)) begin
      w_dec_state = S_DONE;
    end else begin
      w_dec_batch = r_batch + 4'd1;
      w_dec_step  = '0;
    end
  end

  // The decision fires at the end of settling, or directly on done when no settle delay is used.
  always_comb begin
    if (r_state == S_WAIT) begin
      w_decide = i_done_turning && (SETTLE_CYCLES == 0);
    end else if (r_state == S_SETTLE) begin
      w_decide = (r_settle == SET_W'(SETTLE_CYCLES - 1));
    end else begin
      w_decide = 1'b0;
    end
    w_sample = (r_index < IDX_W'(N_CORNER)) ? i_corner_color : i_edge_color;
  end

  // Scan sequencer FSM with registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_batch       <= 4'd0;
      r_step        <= '0;
      r_index       <= '0;
      r_settle      <= '0;
      r_tmo         <= '0;
      r_move_req    <= 1'b0;
      r_move_code   <= 6'd0;
      r_cubestate   <= '0;
      r_busy        <= 1'b0;
      r_state_valid <= 1'b0;
      r_err_color   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_move_req <= 1'b0;
      if (w_decide) begin
        r_state <= w_dec_state;
        r_step  <= w_dec_step;
        r_batch <= w_dec_batch;
        if (w_dec_state == S_ISSUE) begin
          r_move_req  <= 1'b1;
          r_move_code <= f_move_code(w_dec_step, w_dec_batch);
        end else if (w_dec_state == S_DONE) begin
          r_busy        <= 1'b0;
          r_state_valid <= 1'b1;
        end else begin
          r_busy <= r_busy;
        end
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              r_err_color   <= 1'b0;
              r_err_timeout <= 1'b0;
              r_state_valid <= 1'b0;
              r_batch       <= 4'd0;
              r_step        <= '0;
              r_index       <= '0;
              r_busy        <= 1'b1;
              r_move_req    <= 1'b1;
              r_move_code   <= f_move_code('0, 4'd0);
              r_state       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            // A done arriving on the last allowed cycle still counts as in time.
            if (i_done_turning) begin
              r_settle <= '0;
              r_state  <= S_SETTLE;
            end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              r_err_timeout <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          S_SETTLE: begin
            r_settle <= r_settle + SET_W'(1);
          end
          S_SAMPLE: begin
            // Illegal codes are flagged but still stored so the solver can see them.
            r_cubestate[r_index*COLOR_W +: COLOR_W] <= w_sample;
            if (w_sample > COLOR_W'(5)) begin
              r_err_color <= 1'b1;
            end
            r_index     <= r_index + IDX_W'(1);
            r_step      <= r_step + STEP_W'(1);
            r_move_req  <= 1'b1;
            r_move_code <= f_move_code(r_step + STEP_W'(1), r_batch);
            r_state     <= S_ISSUE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_move_req    = r_move_req;
  assign o_move_code   = r_move_code;
  assign o_cubestate   = r_cubestate;
  assign o_busy        = r_busy;
  assign o_state_valid = r_state_valid;
  assign o_err_color   = r_err_color;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Self-checking bench for cube_scan_sequencer: a reactive motor and sensor model drive
// the DUT, and an event-time reference model predicts every output on every cycle.
module tb_cube_scan_sequencer;
  localparam int S  = 4;
  localparam int T  = 64;
  localparam int NS = 48;
  localparam int NC = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_start = 1'b0;
  logic         i_done = 1'b0;
  logic [2:0]   sens_c = 3'd0;
  logic [2:0]   sens_e = 3'd0;
  logic         move_req;
  logic [5:0]   move_code;
  logic [143:0] cube;
  logic         busy, valid, errc, errt;

  cube_scan_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start),
    .i_corner_color(sens_c), .i_edge_color(sens_e), .i_done_turning(i_done),
    .o_move_req(move_req), .o_move_code(move_code), .o_cubestate(cube),
    .o_busy(busy), .o_state_valid(valid), .o_err_color(errc), .o_err_timeout(errt)
  );

  initial forever #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [2:0] st(input int i);
    return cube[i*3 +: 3];
  endfunction

  // ---------------- reference model: event times derived from the move rules ----------------
  int         m_n = 0, m_req = -100, m_next = -1, m_samp = -1, m_done = -1, m_mv = 0, m_k = 0;
  bit         m_act = 1'b0, m_wait = 1'b0;
  bit         m_busy = 1'b0, m_valid = 1'b0, m_errc = 1'b0, m_errt = 1'b0;
  logic [2:0] m_cube [NS];
  logic [2:0] m_v;

  initial begin
    for (int i = 0; i < NS; i++) m_cube[i] = 3'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 0; m_wait = 0; m_busy = 0; m_valid = 0; m_errc = 0; m_errt = 0;
        m_req = -100; m_next = -1; m_samp = -1; m_done = -1; m_mv = 0; m_k = 0;
        for (int i = 0; i < NS; i++) m_cube[i] = 3'd0;
      end else begin
        m_n++;
        if (!m_act) begin
          if (i_start) begin
            m_act = 1; m_busy = 1; m_valid = 0; m_errc = 0; m_errt = 0;
            m_mv = 0; m_k = 0; m_req = m_n; m_wait = 1;
            m_next = -1; m_samp = -1; m_done = -1;
          end
        end else begin
          if (m_n == m_samp) begin
            m_v = (m_k < NC) ? sens_c : sens_e;
            m_cube[m_k] = m_v;
            if (m_v > 3'd5) m_errc = 1;
            m_k++;
          end
          // done is only heard from the second edge after the request onwards
          if (m_wait && m_n >= m_req + 2) begin
            if (i_done) begin
              m_wait = 0;
              if (m_mv % 6 < 4) begin m_samp = m_n + S + 1; m_next = m_n + S + 1; end
              else if (m_mv == 71) m_done = m_n + S;
              else m_next = m_n + S;
            end else if (m_n == m_req + 1 + T) begin
              m_errt = 1; m_busy = 0; m_act = 0; m_wait = 0;
            end
          end
          if (m_n == m_next) begin m_mv++; m_req = m_n; m_wait = 1; m_next = -1; end
          if (m_n == m_done) begin m_busy = 0; m_valid = 1; m_act = 0; m_done = -1; end
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  logic [143:0] exp_cube;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < NS; i++) exp_cube[i*3 +: 3] = m_cube[i];
      chk("move_req", move_req, (m_req == m_n));
      if (m_req == m_n) begin
        if (m_mv % 6 == 0)      chk("move_code", move_code, {2'd0, 4'(m_mv / 6)});
        else if (m_mv % 6 == 5) chk("move_code", move_code, {2'd2, 4'(m_mv / 6)});
        else                    chk("move_kind", move_code[5:4], 2'd1);
      end
      chk("busy", busy, m_busy);
      chk("state_valid", valid, m_valid);
      chk("err_color", errc, m_errc);
      chk("err_timeout", errt, m_errt);
      chk("cubestate", cube, exp_cube);
    end
  end

  // ---------------- stimulus: motor, sensors, start ----------------
  int         nc = 0, cd = 0, spur_cd = 0, alt_cd = 0, req_cnt = 0, req9_t = 0;
  int         sens_mode = 0;
  bit         rand_delay = 0, spur = 0, spam = 0, withhold = 0, alt_hi = 0, start_req = 0;
  bit         done_v;
  logic [5:0] codes [80];

  initial forever begin
    @(negedge clk);
    nc++;
    if (alt_cd > 0) begin alt_cd--; if (alt_cd == 0) alt_hi = 1; end
    done_v = 0;
    if (rst) begin
      cd = 0; spur_cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin done_v = 1; alt_cd = 3; if (spur) spur_cd = 2; end
      end
      if (spur_cd > 0) begin spur_cd--; if (spur_cd == 0) done_v = 1; end
      if (move_req) begin
        alt_hi = 0;
        if (req_cnt < 80) codes[req_cnt] = move_code;
        req_cnt++;
        if (req_cnt == 9) req9_t = nc;
        if (!(withhold && req_cnt >= 9)) cd = rand_delay ? int'($urandom_range(20, 1)) : 10;
        if (spur) done_v = 1;
      end
    end
    i_done = done_v;
    case (sens_mode)
      0: begin sens_c = 3'(m_k % 6); sens_e = 3'(m_k % 6); end
      1: begin sens_c = 3'd5; sens_e = 3'd2; end
      2: begin sens_c = (m_k == 3) ? 3'd7 : 3'(m_k % 6); sens_e = 3'(m_k % 6); end
      3: begin sens_c = 3'($urandom_range(7, 0)); sens_e = 3'($urandom_range(7, 0)); end
      default: begin sens_c = alt_hi ? 3'd4 : 3'd1; sens_e = alt_hi ? 3'd4 : 3'd1; end
    endcase
    i_start = start_req | (spam && m_act && m_mv < 60 && $urandom_range(3, 0) == 0);
  end

  task automatic do_start();
    @(posedge clk); #2 start_req = 1; req_cnt = 0;
    @(posedge clk); #2 start_req = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    chk({"wait_", nm}, ok, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1; cmp_en = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_code", move_code, 6'd0);
    chk("rst_cube", cube, 144'd0);

    // nominal: sticker i reads i%6, motor answers after 10 cycles
    sens_mode = 0;
    do_start();
    wait_idle("nominal", 3000);
    chk("nom_req_count", req_cnt, 72);
    chk("nom_code0", codes[0], 6'h00);
    chk("nom_code1_kind", codes[1][5:4], 2'd1);
    chk("nom_code5", codes[5], 6'h20);
    chk("nom_code6", codes[6], 6'h01);
    chk("nom_code71", codes[71], 6'h2B);
    chk("nom_st7", st(7), 3'd1);
    chk("nom_st47", st(47), 3'd5);
    chk("nom_valid", valid, 1'b1);

    // sensor mux
    sens_mode = 1;
    do_start();
    wait_idle("mux", 3000);
    chk("mux_st0", st(0), 3'd5);
    chk("mux_st23", st(23), 3'd5);
    chk("mux_st24", st(24), 3'd2);
    chk("mux_st47", st(47), 3'd2);
    chk("mux_errc", errc, 1'b0);

    // illegal colour on sticker 3 only
    sens_mode = 2;
    do_start();
    wait_idle("illegal", 3000);
    chk("ill_st3", st(3), 3'd7);
    chk("ill_st4", st(4), 3'd4);
    chk("ill_errc", errc, 1'b1);
    chk("ill_valid", valid, 1'b1);

    // sensor changes 3 cycles after done: the new value must be captured
    sens_mode = 4;
    do_start();
    wait_idle("settle", 3000);
    chk("settle_st0", st(0), 3'd4);
    chk("settle_st30", st(30), 3'd4);

    // random sensors and delays, spurious dones, start while busy
    sens_mode = 3; rand_delay = 1; spur = 1; spam = 1;
    do_start();
    wait_idle("random", 4000);
    chk("rand_valid", valid, 1'b1);
    spur = 0; spam = 0; rand_delay = 0;

    // timeout after the 9th move request
    sens_mode = 0; withhold = 1;
    do_start();
    wait_idle("timeout", 3000);
    chk("tmo_latency", nc - req9_t, 65);
    chk("tmo_errt", errt, 1'b1);
    chk("tmo_valid", valid, 1'b0);
    withhold = 0;
    do_start();
    chk("tmo_cleared", errt, 1'b0);
    wait_idle("after_tmo", 3000);
    chk("after_tmo_valid", valid, 1'b1);

    // asynchronous reset in batch 5
    sens_mode = 3; rand_delay = 1;
    do_start();
    begin
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk); #1;
        if (req_cnt >= 32) begin ok = 1; break; end
      end
      chk("reach_batch5", ok, 1'b1);
    end
    @(posedge clk); #3 rst = 1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_req", move_req, 1'b0);
    chk("arst_code", move_code, 6'd0);
    chk("arst_cube", cube, 144'd0);
    chk("arst_errc", errc, 1'b0);
    repeat (2) @(negedge clk);
    rst = 0;
    sens_mode = 0; rand_delay = 0;
    do_start();
    wait_idle("rescan", 3000);
    chk("rescan_code0", codes[0], 6'h00);
    chk("rescan_req_count", req_cnt, 72);
    chk("rescan_st10", st(10), 3'd4);
    chk("rescan_valid", valid, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
